// File: rtl/stream_port_pkg.sv
// Shared types and constants for the AXI4-Stream video port blocks.
package stream_port_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitSof,
        StActive,
        StDrop
    } state_e;

    localparam string ModeOnce = "ONCE";
    localparam string ModeLine = "LINE";

    // A zero geometry value would make the equality compares unreachable; treat it as 1.
    function automatic logic [15:0] clamp_geom(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/axis_line_tracker.sv
// Pixel/line counters with latched frame geometry for the stream-in port.
// On an SOF beat the compare flags use the incoming geometry and zeroed counters, so the
// SOF beat itself can also be the last pixel of the line and of the frame.
module axis_line_tracker
    import stream_port_pkg::*;
(
    input  logic        clock_i,
    input  logic        rst_ni,
    input  logic        sof_i,       // beat restarts the frame (pixel 0, line 0)
    input  logic        pix_i,       // beat is a written pixel
    input  logic        close_i,     // beat closes the current line
    input  logic [15:0] hactive_i,
    input  logic [15:0] vactive_i,
    output logic        pix_last_o,  // this beat is pixel hactive-1
    output logic        line_last_o  // closing now completes vactive lines
);

    logic [15:0] pcnt_q, pcnt_d, lcnt_q, lcnt_d;
    logic [15:0] hact_q, hact_d, vact_q, vact_d;
    logic [15:0] pcnt_eff, lcnt_eff, hact_eff, vact_eff;

    // Effective counters/geometry for the current beat, compare flags and next state.
    always_comb begin
        pcnt_eff    = sof_i ? 16'd0 : pcnt_q;
        lcnt_eff    = sof_i ? 16'd0 : lcnt_q;
        hact_eff    = sof_i ? clamp_geom(hactive_i) : hact_q;
        vact_eff    = sof_i ? clamp_geom(vactive_i) : vact_q;
        pix_last_o  = (pcnt_eff + 16'd1) == hact_eff;
        line_last_o = (lcnt_eff + 16'd1) == vact_eff;

        pcnt_d = pcnt_q;
        lcnt_d = lcnt_q;
        hact_d = hact_eff;
        vact_d = vact_eff;
        if (close_i) begin
            pcnt_d = 16'd0;
            lcnt_d = lcnt_eff + 16'd1;
        end else if (pix_i) begin
            pcnt_d = pcnt_eff + 16'd1;
            lcnt_d = lcnt_eff;
        end
    end

    // Counter and geometry registers.
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q <= 16'd0;
            lcnt_q <= 16'd0;
            hact_q <= 16'd0;
            vact_q <= 16'd0;
        end else begin
            pcnt_q <= pcnt_d;
            lcnt_q <= lcnt_d;
            hact_q <= hact_d;
            vact_q <= vact_d;
        end
    end

endmodule

// File: rtl/axis_stream_in_port.sv
// AXI4-Stream video slave: checks line/frame geometry, writes pixels to the VDMA FIFO and
// emits frame/line/end alignment pulses. Optional error counter: STREAM_IN_ERR_CNT_EN.
module axis_stream_in_port
    import stream_port_pkg::*;
#(
    parameter int unsigned DSIZE = 24,
    parameter string       MODE  = "ONCE"
) (
    input  logic             clock_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [15:0]      vactive_i,
    input  logic [15:0]      hactive_i,
    input  logic [DSIZE-1:0] axi_tdata_i,
    input  logic             axi_tvalid_i,
    output logic             axi_tready_o,
    input  logic             axi_tuser_i,
    input  logic             axi_tlast_i,
    input  logic             fifo_afull_i,
    output logic             wr_en_o,
    output logic [DSIZE-1:0] wr_data_o,
    output logic             falign_o,
    output logic             lalign_o,
    output logic             ealign_o,
    output logic             eol_early_o,
    output logic             eol_late_o,
    output logic             sof_err_o,
    output logic [15:0]      err_cnt_o
);

    localparam bit LineMode = (MODE == ModeLine);

    state_e           state_q;
    logic             beat, sof, pix, close;
    logic             pix_last, line_last;
    logic             wr_en_q, falign_q, lalign_q, ealign_q;
    logic             eol_early_q, eol_late_q, sof_err_q;
    logic [DSIZE-1:0] wr_data_q;

    assign axi_tready_o = (state_q != StIdle) && !fifo_afull_i;

    // Beat classification; an SOF in WAIT_SOF is ignored while enable is being dropped.
    always_comb begin
        beat  = axi_tvalid_i && axi_tready_o;
        sof   = beat && axi_tuser_i &&
                ((state_q == StActive) || (state_q == StDrop) ||
                 ((state_q == StWaitSof) && enable_i));
        pix   = sof || (beat && (state_q == StActive));
        close = axi_tlast_i && (pix || (beat && (state_q == StDrop)));
    end

    axis_line_tracker u_tracker (
        .clock_i     (clock_i),
        .rst_ni      (rst_ni),
        .sof_i       (sof),
        .pix_i       (pix),
        .close_i     (close),
        .hactive_i   (hactive_i),
        .vactive_i   (vactive_i),
        .pix_last_o  (pix_last),
        .line_last_o (line_last)
    );

    // Receive FSM with registered FIFO write and pulse outputs.
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            falign_q    <= 1'b0;
            lalign_q    <= 1'b0;
            ealign_q    <= 1'b0;
            eol_early_q <= 1'b0;
            eol_late_q  <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            wr_en_q     <= pix;
            falign_q    <= sof;
            sof_err_q   <= sof && ((state_q == StActive) || (state_q == StDrop));
            lalign_q    <= 1'b0;
            ealign_q    <= 1'b0;
            eol_early_q <= 1'b0;
            eol_late_q  <= 1'b0;
            if (pix) begin
                wr_data_q <= axi_tdata_i;
            end
            if (pix) begin
                if (axi_tlast_i) begin
                    if (pix_last) begin
                        lalign_q <= LineMode;
                    end else begin
                        eol_early_q <= 1'b1;
                    end
                    if (line_last) begin
                        ealign_q <= 1'b1;
                        state_q  <= StWaitSof;
                    end else begin
                        state_q <= StActive;
                    end
                end else if (pix_last) begin
                    eol_late_q <= 1'b1;
                    state_q    <= StDrop;
                end else begin
                    state_q <= StActive;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (enable_i) state_q <= StWaitSof;
                    end
                    StWaitSof: begin
                        if (!enable_i) state_q <= StIdle;
                    end
                    StActive: begin
                    end
                    StDrop: begin
                        if (close) begin
                            if (line_last) begin
                                ealign_q <= 1'b1;
                                state_q  <= StWaitSof;
                            end else begin
                                state_q <= StActive;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_data_o   = wr_data_q;
    assign falign_o    = falign_q;
    assign lalign_o    = lalign_q;
    assign ealign_o    = ealign_q;
    assign eol_early_o = eol_early_q;
    assign eol_late_o  = eol_late_q;
    assign sof_err_o   = sof_err_q;

`ifdef STREAM_IN_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of cycles with any geometry error pulse.
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= 16'd0;
        end else if ((eol_early_q || eol_late_q || sof_err_q) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_axis_stream_in_port.sv
// Directed bench for axis_stream_in_port (LINE mode so lalign is observable).
module tb_axis_stream_in_port;

    localparam int unsigned DSIZE = 24;
`ifdef STREAM_IN_ERR_CNT_EN
    localparam int ErrOn = 1;
`else
    localparam int ErrOn = 0;
`endif

    // Flag vector bits: {wr_en, falign, lalign, ealign, eol_early, eol_late, sof_err}
    localparam logic [6:0] FW  = 7'b1000000;
    localparam logic [6:0] FFA = 7'b0100000;
    localparam logic [6:0] FLA = 7'b0010000;
    localparam logic [6:0] FEA = 7'b0001000;
    localparam logic [6:0] FEE = 7'b0000100;
    localparam logic [6:0] FEL = 7'b0000010;
    localparam logic [6:0] FSE = 7'b0000001;
    localparam logic [6:0] F0  = 7'b0000000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [15:0]      vactive, hactive;
    logic [DSIZE-1:0] tdata;
    logic             tvalid, tready, tuser, tlast, afull;
    logic             wr_en, falign, lalign, ealign, eol_early, eol_late, sof_err;
    logic [DSIZE-1:0] wr_data;
    logic [15:0]      err_cnt;
    logic [6:0]       flags;
    logic             rdy_seen;
    int               pass_cnt = 0;
    int               fail_cnt = 0;
    int               total_cnt = 0;

    always #5 clk = ~clk;

    assign flags = {wr_en, falign, lalign, ealign, eol_early, eol_late, sof_err};

    axis_stream_in_port #(
        .DSIZE (DSIZE),
        .MODE  ("LINE")
    ) dut (
        .clock_i      (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .vactive_i    (vactive),
        .hactive_i    (hactive),
        .axi_tdata_i  (tdata),
        .axi_tvalid_i (tvalid),
        .axi_tready_o (tready),
        .axi_tuser_i  (tuser),
        .axi_tlast_i  (tlast),
        .fifo_afull_i (afull),
        .wr_en_o      (wr_en),
        .wr_data_o    (wr_data),
        .falign_o     (falign),
        .lalign_o     (lalign),
        .ealign_o     (ealign),
        .eol_early_o  (eol_early),
        .eol_late_o   (eol_late),
        .sof_err_o    (sof_err),
        .err_cnt_o    (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs from a negedge; outputs are sampled at the following negedge.
    task automatic step(input logic v, input logic u, input logic l, input logic [DSIZE-1:0] d,
                        input logic af);
        tvalid = v;
        tuser  = u;
        tlast  = l;
        tdata  = d;
        afull  = af;
        #1 rdy_seen = tready;
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input logic u, input logic l,
                        input logic [DSIZE-1:0] d, input logic [6:0] exp_f);
        step(1'b1, u, l, d, 1'b0);
        chk({tag, " rdy"}, 32'(rdy_seen), 32'd1);
        chk({tag, " flags"}, 32'(flags), 32'(exp_f));
        if (exp_f[6]) chk({tag, " data"}, 32'(wr_data), 32'(d));
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        hactive = 16'd4;
        vactive = 16'd2;
        tvalid  = 1'b0;
        tuser   = 1'b0;
        tlast   = 1'b0;
        tdata   = '0;
        afull   = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst flags", 32'(flags), 32'(F0));
        chk("rst data", 32'(wr_data), 32'd0);
        chk("rst err_cnt", 32'(err_cnt), 32'd0);
        chk("rst tready", 32'(tready), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("idle tready", 32'(tready), 32'd0);
        enable = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("wait_sof tready", 32'(tready), 32'd1);

        // Beats before SOF are drained, not written
        for (int i = 0; i < 3; i++) beat($sformatf("drain%0d", i), 1'b0, 1'b0, 24'h50 + 24'(i), F0);

        // Clean 4x2 frame
        for (int i = 0; i < 8; i++) begin
            logic u, l;
            u = (i == 0);
            l = (i == 3) || (i == 7);
            beat($sformatf("clean%0d", i), u, l, 24'h100 + 24'(i),
                 FW | (u ? FFA : F0) | (l ? FLA : F0) | ((i == 7) ? FEA : F0));
        end
        beat("post_frame drain", 1'b0, 1'b0, 24'h1FF, F0);

        // Early EOL on pixel 2, next line of 4 completes the frame
        beat("early0", 1'b1, 1'b0, 24'h200, FW | FFA);
        beat("early1", 1'b0, 1'b0, 24'h201, FW);
        beat("early2", 1'b0, 1'b1, 24'h202, FW | FEE);
        for (int i = 0; i < 4; i++)
            beat($sformatf("early_l1_%0d", i), 1'b0, i == 3, 24'h210 + 24'(i),
                 FW | ((i == 3) ? (FLA | FEA) : F0));
        chk("err_cnt after early", 32'(err_cnt), 32'(ErrOn * 1));

        // Late EOL: pixels 4..6 dropped, line counted on tlast
        beat("late0", 1'b1, 1'b0, 24'h300, FW | FFA);
        beat("late1", 1'b0, 1'b0, 24'h301, FW);
        beat("late2", 1'b0, 1'b0, 24'h302, FW);
        beat("late3", 1'b0, 1'b0, 24'h303, FW | FEL);
        beat("late4", 1'b0, 1'b0, 24'h304, F0);
        beat("late5", 1'b0, 1'b0, 24'h305, F0);
        beat("late6", 1'b0, 1'b1, 24'h306, F0);
        for (int i = 0; i < 4; i++)
            beat($sformatf("late_l1_%0d", i), 1'b0, i == 3, 24'h310 + 24'(i),
                 FW | ((i == 3) ? (FLA | FEA) : F0));
        chk("err_cnt after late", 32'(err_cnt), 32'(ErrOn * 2));

        // SOF arriving at line 1 pixel 2 restarts the frame
        for (int i = 0; i < 4; i++)
            beat($sformatf("sof_l0_%0d", i), i == 0, i == 3, 24'h400 + 24'(i),
                 FW | ((i == 0) ? FFA : F0) | ((i == 3) ? FLA : F0));
        beat("sof_l1_0", 1'b0, 1'b0, 24'h410, FW);
        beat("sof_l1_1", 1'b0, 1'b0, 24'h411, FW);
        beat("sof_err", 1'b1, 1'b0, 24'h412, FW | FFA | FSE);
        for (int i = 1; i < 4; i++)
            beat($sformatf("restart_l0_%0d", i), 1'b0, i == 3, 24'h420 + 24'(i),
                 FW | ((i == 3) ? FLA : F0));
        for (int i = 0; i < 4; i++)
            beat($sformatf("restart_l1_%0d", i), 1'b0, i == 3, 24'h430 + 24'(i),
                 FW | ((i == 3) ? (FLA | FEA) : F0));
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("err_cnt after sof_err", 32'(err_cnt), 32'(ErrOn * 3));

        // hactive = vactive = 1: one beat is SOF, EOL and EOF at once
        hactive = 16'd1;
        vactive = 16'd1;
        beat("single", 1'b1, 1'b1, 24'h500, FW | FFA | FLA | FEA);
        hactive = 16'd4;
        vactive = 16'd2;

        // fifo_afull stall mid-line keeps data order
        beat("afull0", 1'b1, 1'b0, 24'hA0, FW | FFA);
        beat("afull1", 1'b0, 1'b0, 24'hA1, FW);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 24'hA2, 1'b1);
            chk($sformatf("stall%0d rdy", i), 32'(rdy_seen), 32'd0);
            chk($sformatf("stall%0d flags", i), 32'(flags), 32'(F0));
        end
        beat("afull2", 1'b0, 1'b0, 24'hA2, FW);
        beat("afull3", 1'b0, 1'b1, 24'hA3, FW | FLA);
        beat("afull_l1_0", 1'b0, 1'b0, 24'hB0, FW);

        // Asynchronous reset mid-frame
        tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst flags", 32'(flags), 32'(F0));
        chk("midrst data", 32'(wr_data), 32'd0);
        chk("midrst err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst tready", 32'(tready), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("post rst idle tready", 32'(tready), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
